// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game controller.
package pong_pkg;

  typedef enum logic [2:0] {
    MENU,
    SERVE,
    PLAY,
    WIN1,
    WIN2
  } game_state_t;

  localparam logic [1:0] DISP_MENU  = 2'b00;
  localparam logic [1:0] DISP_PLAY  = 2'b01;
  localparam logic [1:0] DISP_P1WIN = 2'b10;
  localparam logic [1:0] DISP_P2WIN = 2'b11;

  localparam int SCREEN_W = 640;

  function automatic logic [1:0] disp_of(input game_state_t s);
    case (s)
      SERVE, PLAY: disp_of = DISP_PLAY;
      WIN1:        disp_of = DISP_P1WIN;
      WIN2:        disp_of = DISP_P2WIN;
      default:     disp_of = DISP_MENU;
    endcase
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame up-counter with clear, enable and terminal-count compare.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic [W-1:0] i_tc_val,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)       r_count <= '0;
    else if (i_clr)   r_count <= '0;
    else if (i_load)  r_count <= i_load_val;
    else if (i_en)    r_count <= r_count + 1'b1;
  end

  assign o_tc = (r_count == i_tc_val);

endmodule

// File: rtl/game_ctrl.sv
// Pong game state controller (menu/serve/play/win, scores, serve hold).
// Optional macro GAME_AUTORETURN_EN: win screens return to menu after WIN_HOLD frames.
module game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_HOLD    = 180,
  parameter int MISS_LEFT   = 8,
  parameter int MISS_RIGHT  = 631
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic [9:0] BallX,
  output logic [1:0] Display,
  output logic [8:0] score_1,
  output logic [8:0] score_2,
  output logic       ball_hold,
  output logic       serve_dir
);

  // Timer is shared by the serve delay and the win hold, so size it for the longer one.
  localparam int MAX_T = (SERVE_DELAY > WIN_HOLD) ? SERVE_DELAY : WIN_HOLD;
  localparam int TW    = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] SERVE_TC = TW'(SERVE_DELAY - 1);
  localparam logic [9:0]    MISS_L   = 10'(MISS_LEFT);
  localparam logic [9:0]    MISS_R   = 10'(MISS_RIGHT);
  localparam logic [9:0]    SCR_W    = 10'(SCREEN_W);
  localparam logic [8:0]    WIN_S    = 9'(WIN_SCORE);

  game_state_t   r_state, w_state_nxt;
  logic          r_start_q;
  logic [8:0]    r_score_1, r_score_2, w_score_1_nxt, w_score_2_nxt;
  logic          r_serve_dir, w_serve_dir_nxt;
  logic [1:0]    r_display;
  logic          r_ball_hold;
  logic          w_start_rise, w_left_miss, w_right_miss;
  logic          w_tmr_clr, w_tmr_en, w_tmr_tc;
  logic [TW-1:0] w_tc_val;

  assign w_start_rise = start & ~r_start_q;
  // A wrapped negative X reads as >= SCREEN_W and belongs to the left side.
  assign w_left_miss  = (BallX < MISS_L) | (BallX >= SCR_W);
  assign w_right_miss = (BallX > MISS_R) & (BallX < SCR_W);

  frame_timer #(.W(TW)) u_timer (
    .clk        (frame_clk),
    .rst_n      (Reset_n),
    .i_clr      (w_tmr_clr),
    .i_en       (w_tmr_en),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_tc_val   (w_tc_val),
    .o_tc       (w_tmr_tc)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_score_1_nxt   = r_score_1;
    w_score_2_nxt   = r_score_2;
    w_serve_dir_nxt = r_serve_dir;
    w_tmr_clr       = 1'b0;
    w_tmr_en        = 1'b0;
    w_tc_val        = SERVE_TC;
    case (r_state)
      MENU: begin
        if (w_start_rise) begin
          w_state_nxt     = SERVE;
          w_score_1_nxt   = '0;
          w_score_2_nxt   = '0;
          w_serve_dir_nxt = 1'b1;
          w_tmr_clr       = 1'b1;
        end
      end
      SERVE: begin
        if (w_tmr_tc) begin
          w_state_nxt = PLAY;
          w_tmr_clr   = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      PLAY: begin
        if (w_left_miss) begin
          w_score_2_nxt   = r_score_2 + 9'd1;
          w_serve_dir_nxt = 1'b0;
          w_tmr_clr       = 1'b1;
          w_state_nxt     = (w_score_2_nxt == WIN_S) ? WIN2 : SERVE;
        end else if (w_right_miss) begin
          w_score_1_nxt   = r_score_1 + 9'd1;
          w_serve_dir_nxt = 1'b1;
          w_tmr_clr       = 1'b1;
          w_state_nxt     = (w_score_1_nxt == WIN_S) ? WIN1 : SERVE;
        end
      end
      WIN1, WIN2: begin
`ifdef GAME_AUTORETURN_EN
        w_tc_val = TW'(WIN_HOLD - 1);
        if (w_tmr_tc) begin
          w_state_nxt = MENU;
          w_tmr_clr   = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
        end
`else
        if (w_start_rise) w_state_nxt = MENU;
`endif
      end
      default: w_state_nxt = MENU;
    endcase
  end

  // Display and ball_hold are registered from the next state to keep one-cycle latency.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      r_state     <= MENU;
      r_start_q   <= 1'b1;
      r_score_1   <= '0;
      r_score_2   <= '0;
      r_serve_dir <= 1'b1;
      r_display   <= DISP_MENU;
      r_ball_hold <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_start_q   <= start;
      r_score_1   <= w_score_1_nxt;
      r_score_2   <= w_score_2_nxt;
      r_serve_dir <= w_serve_dir_nxt;
      r_display   <= disp_of(w_state_nxt);
      r_ball_hold <= (w_state_nxt != PLAY);
    end
  end

  assign Display   = r_display;
  assign score_1   = r_score_1;
  assign score_2   = r_score_2;
  assign ball_hold = r_ball_hold;
  assign serve_dir = r_serve_dir;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus random play vs. a countdown model.
module tb_game_ctrl;

  localparam int WIN_SCORE   = 7;
  localparam int SERVE_DELAY = 60;
  localparam int WIN_HOLD    = 180;

  localparam int M_MENU = 0, M_SERVE = 1, M_PLAY = 2, M_WIN1 = 3, M_WIN2 = 4;
  localparam int SAFE_X = 320;

  logic       frame_clk;
  logic       Reset_n;
  logic       start;
  logic [9:0] BallX;
  logic [1:0] Display;
  logic [8:0] score_1, score_2;
  logic       ball_hold, serve_dir;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: game phase, scores and a frames-remaining countdown.
  int m_mode, m_s1, m_s2, m_dir, m_wait;
  bit m_prev_start;

  game_ctrl #(
    .WIN_SCORE   (WIN_SCORE),
    .SERVE_DELAY (SERVE_DELAY),
    .WIN_HOLD    (WIN_HOLD),
    .MISS_LEFT   (8),
    .MISS_RIGHT  (631)
  ) u_dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .BallX     (BallX),
    .Display   (Display),
    .score_1   (score_1),
    .score_2   (score_2),
    .ball_hold (ball_hold),
    .serve_dir (serve_dir)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int m_display();
    case (m_mode)
      M_SERVE, M_PLAY: return 1;
      M_WIN1:          return 2;
      M_WIN2:          return 3;
      default:         return 0;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit st, input int bx);
    bit rise, left, right;
    if (!rst) begin
      m_mode = M_MENU; m_s1 = 0; m_s2 = 0; m_dir = 1; m_wait = 0;
      m_prev_start = 1'b1;
      return;
    end
    rise  = st && !m_prev_start;
    m_prev_start = st;
    left  = (bx < 8) || (bx >= 640);
    right = (bx > 631) && (bx < 640);
    case (m_mode)
      M_MENU: if (rise) begin
        m_mode = M_SERVE; m_s1 = 0; m_s2 = 0; m_dir = 1; m_wait = SERVE_DELAY;
      end
      M_SERVE: begin
        m_wait--;
        if (m_wait == 0) m_mode = M_PLAY;
      end
      M_PLAY: begin
        if (left) begin
          m_s2++; m_dir = 0;
          if (m_s2 == WIN_SCORE) begin m_mode = M_WIN2; m_wait = WIN_HOLD; end
          else begin m_mode = M_SERVE; m_wait = SERVE_DELAY; end
        end else if (right) begin
          m_s1++; m_dir = 1;
          if (m_s1 == WIN_SCORE) begin m_mode = M_WIN1; m_wait = WIN_HOLD; end
          else begin m_mode = M_SERVE; m_wait = SERVE_DELAY; end
        end
      end
      default: begin
`ifdef GAME_AUTORETURN_EN
        m_wait--;
        if (m_wait == 0) m_mode = M_MENU;
`else
        if (rise) m_mode = M_MENU;
`endif
      end
    endcase
  endtask

  // One frame: drive inputs, advance the model, sample outputs on the falling edge.
  task automatic cyc(input bit rst, input bit st, input int bx);
    Reset_n = rst;
    start   = st;
    BallX   = 10'(bx);
    model_step(rst, st, bx);
    @(posedge frame_clk);
    @(negedge frame_clk);
    check("display",   int'(Display),   m_display());
    check("score_1",   int'(score_1),   m_s1);
    check("score_2",   int'(score_2),   m_s2);
    check("ball_hold", int'(ball_hold), (m_mode == M_PLAY) ? 0 : 1);
    check("serve_dir", int'(serve_dir), m_dir);
  endtask

  task automatic wait_mode(input int target);
    int budget = 400;
    while (m_mode != target && budget > 0) begin
      cyc(1'b1, 1'b0, SAFE_X);
      budget--;
    end
    if (m_mode != target) check("wait_mode_timeout", m_mode, target);
  endtask

  task automatic score_point(input bit p1);
    wait_mode(M_PLAY);
    cyc(1'b1, 1'b0, p1 ? 635 : 3);
  endtask

  initial begin
    int n_serve;
    Reset_n = 1'b0; start = 1'b1; BallX = 10'(SAFE_X);

    // Reset with start held: no game may begin.
    cyc(1'b0, 1'b1, SAFE_X);
    cyc(1'b0, 1'b1, SAFE_X);
    check("rst_display", int'(Display), 0);
    check("rst_hold", int'(ball_hold), 1);
    check("rst_dir", int'(serve_dir), 1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, SAFE_X);
    check("held_start_menu", int'(Display), 0);

    // Release, pulse start, measure the serve hold.
    cyc(1'b1, 1'b0, SAFE_X);
    cyc(1'b1, 1'b1, SAFE_X);
    check("serve_display", int'(Display), 1);
    n_serve = 1;
    for (int i = 0; i < 80; i++) begin
      cyc(1'b1, 1'b0, SAFE_X);
      if (ball_hold) n_serve++;
      else break;
    end
    check("serve_len", n_serve, SERVE_DELAY);

    // Ball parked in the left miss zone scores only once.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 3);
    check("left_once_s2", int'(score_2), 1);
    check("left_dir", int'(serve_dir), 0);
    check("left_to_serve", int'(ball_hold), 1);

    // Wrapped X counts as left; 635 is a right miss.
    score_point(1'b0);
    BallX = 10'd1020;
    wait_mode(M_PLAY);
    cyc(1'b1, 1'b0, 1020);
    check("wrap_s2", int'(score_2), 3);
    score_point(1'b1);
    check("right_s1", int'(score_1), 1);
    check("right_dir", int'(serve_dir), 1);

    // P1 to the winning score.
    for (int i = 0; i < WIN_SCORE - 1; i++) score_point(1'b1);
    check("win1_display", int'(Display), 2);
    check("win1_score", int'(score_1), WIN_SCORE);
`ifdef GAME_AUTORETURN_EN
    for (int i = 0; i < WIN_HOLD - 1; i++) cyc(1'b1, (i % 7) == 3, SAFE_X);
    check("win_hold_still", int'(Display), 2);
    cyc(1'b1, 1'b0, SAFE_X);
    check("autoreturn_menu", int'(Display), 0);
`else
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, SAFE_X);
    check("win_stays", int'(Display), 2);
    cyc(1'b1, 1'b1, SAFE_X);
    check("win_start_menu", int'(Display), 0);
    cyc(1'b1, 1'b0, SAFE_X);
`endif

    // Mid-game reset with scores 3/5.
    cyc(1'b1, 1'b0, SAFE_X);
    cyc(1'b1, 1'b1, SAFE_X);
    for (int i = 0; i < 3; i++) score_point(1'b1);
    for (int i = 0; i < 5; i++) score_point(1'b0);
    wait_mode(M_PLAY);
    check("pre_rst_s1", int'(score_1), 3);
    check("pre_rst_s2", int'(score_2), 5);
    cyc(1'b0, 1'b0, SAFE_X);
    check("midrst_display", int'(Display), 0);
    check("midrst_s1", int'(score_1), 0);
    check("midrst_s2", int'(score_2), 0);
    check("midrst_hold", int'(ball_hold), 1);

    // Randomized play against the model.
    for (int i = 0; i < 4000; i++) begin
      bit rst_b, st_b;
      int bx;
      rst_b = ($urandom_range(0, 599) != 0);
      st_b  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 9))
        0:       bx = $urandom_range(0, 1023);
        1:       bx = $urandom_range(600, 660);
        2:       bx = $urandom_range(0, 12);
        default: bx = $urandom_range(100, 500);
      endcase
      cyc(rst_b, st_b, bx);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
